// File: rtl/clk_tick_ctrl_pkg.sv
// clk_tick_ctrl_pkg: shared state encoding and default widths for the tick controller
package clk_tick_ctrl_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DIV_MIN   = 1;
endpackage

// File: rtl/clk_tick_prescale.sv
// clk_tick_prescale: prescale counter that wraps at div-1 and flags the terminal count
module clk_tick_prescale
    import clk_tick_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    assign tc = (cnt_q == div - DIV_W'(DIV_MIN));
    // next count: clear wins, otherwise count up and wrap on terminal count
    always_comb begin
        cnt_d = clr ? '0 : (en ? (tc ? '0 : cnt_q + DIV_W'(1)) : cnt_q);
    end
    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clk_tick_ctrl.sv
// clk_tick_ctrl: turns the system clock into programmable clock-enable ticks (optional square output under CLK_TICK_CTRL_SQUARE_EN)
module clk_tick_ctrl
    import clk_tick_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic [DIV_W-1:0] CFG_DIV,
    input  logic [CNT_W-1:0] CFG_BURST,
    input  logic             START,
    input  logic             STOP,
    output logic             TICK,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] TICK_CNT
`ifdef CLK_TICK_CTRL_SQUARE_EN
    ,
    output logic             CLK_DIV_OUT
`endif
);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             idle, run, cfg_acc, start, tc, tick_ev, last;
    logic [CNT_W-1:0] cnt_inc;

    assign idle      = (state_q == ST_IDLE);
    assign run       = (state_q == ST_RUN);
    assign cfg_acc   = CFG_VALID && idle;
    assign start     = idle && START && !STOP;
    assign tick_ev   = run && !STOP && tc;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last      = tick_ev && (burst_q != '0) && (cnt_inc == burst_q);
    assign CFG_READY = idle;
    assign BUSY      = run;
    assign TICK      = tick_q;
    assign DONE      = done_q;
    assign TICK_CNT  = cnt_q;

    clk_tick_prescale #(.DIV_W(DIV_W)) u_prescale (
        .clk   (CLK),
        .rst_n (CLR),
        .clr   (start),
        .en    (run),
        .div   (div_q),
        .tc    (tc)
    );

    // next-state: FSM transitions, config capture and tick/burst accounting
    always_comb begin
        state_d = idle ? (start ? ST_RUN : ST_IDLE) : ((STOP || last) ? ST_IDLE : ST_RUN);
        div_d   = cfg_acc ? ((CFG_DIV == '0) ? DIV_W'(DIV_MIN) : CFG_DIV) : div_q;
        burst_d = cfg_acc ? CFG_BURST : burst_q;
        cnt_d   = start ? '0 : (tick_ev ? cnt_inc : cnt_q);
        tick_d  = tick_ev;
        done_d  = last;
    end

    // state and output registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_W'(DIV_MIN);
            burst_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

`ifdef CLK_TICK_CTRL_SQUARE_EN
    logic sq_q, sq_d;
    assign CLK_DIV_OUT = sq_q;
    // square wave flips on each tick and is parked low whenever the controller is idle
    always_comb begin
        sq_d = (state_d == ST_IDLE) ? 1'b0 : (tick_ev ? ~sq_q : sq_q);
    end
    // square wave register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) sq_q <= 1'b0;
        else      sq_q <= sq_d;
    end
`endif
endmodule

// File: tb/tb_clk_tick_ctrl.sv
// tb_clk_tick_ctrl: directed scoreboard bench for clk_tick_ctrl
module tb_clk_tick_ctrl;
    localparam int DIV_W = 8;
    localparam int CNT_W = 16;

    typedef struct {
        int cyc;
        int cnt;
        bit done;
    } exp_t;

    logic             CLK = 1'b0;
    logic             CLR = 1'b0;
    logic             CFG_VALID = 1'b0;
    logic             CFG_READY;
    logic [DIV_W-1:0] CFG_DIV = '0;
    logic [CNT_W-1:0] CFG_BURST = '0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic             TICK, BUSY, DONE;
    logic [CNT_W-1:0] TICK_CNT;
`ifdef CLK_TICK_CTRL_SQUARE_EN
    logic             CLK_DIV_OUT;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   e0;

    clk_tick_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_DIV   (CFG_DIV),
        .CFG_BURST (CFG_BURST),
        .START     (START),
        .STOP      (STOP),
        .TICK      (TICK),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .TICK_CNT  (TICK_CNT)
`ifdef CLK_TICK_CTRL_SQUARE_EN
        ,
        .CLK_DIV_OUT (CLK_DIV_OUT)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic cfg(input int div, input int burst);
        CFG_VALID = 1'b1;
        CFG_DIV   = DIV_W'(div);
        CFG_BURST = CNT_W'(burst);
        step(1);
        CFG_VALID = 1'b0;
    endtask

    task automatic go();
        START = 1'b1;
        step(1);
        START = 1'b0;
        e0 = cyc;
    endtask

    task automatic expect_ticks(input int div, input int n, input int burst);
        for (int k = 1; k <= n; k++) begin
            exp_t e;
            e.cyc  = e0 + k * div;
            e.cnt  = k;
            e.done = (burst != 0) && (k == burst);
            q.push_back(e);
        end
    endtask

    // monitor: every TICK or DONE pulse must match the next scoreboard entry
    always @(negedge CLK) begin
        if (CLR && (TICK || DONE)) begin
            if (q.size() == 0) begin
                chk("unexpected_tick", int'(TICK), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_pulse", int'(TICK), 1);
                chk("tick_cnt_at_tick", int'(TICK_CNT), e.cnt);
                chk("done_at_tick", int'(DONE), int'(e.done));
            end
        end
    end

    initial begin
        #2;
        chk("rst_tick", int'(TICK), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_cnt", int'(TICK_CNT), 0);
        chk("rst_ready", int'(CFG_READY), 1);
        @(negedge CLK);
        CLR = 1'b1;
        step(1);

        // free-running DIV=3, then asynchronous reset mid-run
        cfg(3, 0);
        go();
        chk("busy_after_start", int'(BUSY), 1);
        chk("ready_in_run", int'(CFG_READY), 0);
        expect_ticks(3, 2, 0);
        step(7);
        chk("ticks_before_reset", q.size(), 0);
        #2 CLR = 1'b0;
        #1;
        chk("midrun_rst_busy", int'(BUSY), 0);
        chk("midrun_rst_tick", int'(TICK), 0);
        chk("midrun_rst_cnt", int'(TICK_CNT), 0);
        chk("midrun_rst_ready", int'(CFG_READY), 1);
        @(negedge CLK);
        CLR = 1'b1;
        step(6);
        chk("idle_after_reset", int'(BUSY), 0);

        // DIV=4 BURST=3
        cfg(4, 3);
        go();
        expect_ticks(4, 3, 3);
        step(11);
        chk("burst3_busy_before_end", int'(BUSY), 1);
        step(1);
        chk("burst3_busy_end", int'(BUSY), 0);
        chk("burst3_cnt", int'(TICK_CNT), 3);
        chk("burst3_ready", int'(CFG_READY), 1);
        step(2);
        chk("burst3_all_ticks", q.size(), 0);
        chk("burst3_cnt_hold", int'(TICK_CNT), 3);

        // DIV=0 treated as 1, BURST=5, config on the start edge
        CFG_VALID = 1'b1;
        CFG_DIV   = '0;
        CFG_BURST = CNT_W'(5);
        go();
        CFG_VALID = 1'b0;
        expect_ticks(1, 5, 5);
        step(7);
        chk("div0_all_ticks", q.size(), 0);
        chk("div0_cnt", int'(TICK_CNT), 5);
        chk("div0_busy", int'(BUSY), 0);

        // DIV=5 free-running, STOP on a due tick, config offered in RUN
        cfg(5, 0);
        go();
        expect_ticks(5, 1, 0);
        step(1);
        chk("ready_low_run", int'(CFG_READY), 0);
        CFG_VALID = 1'b1;
        CFG_DIV   = DIV_W'(9);
        CFG_BURST = CNT_W'(2);
        step(1);
        CFG_VALID = 1'b0;
        step(7);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        chk("stop_tick", int'(TICK), 0);
        chk("stop_cnt", int'(TICK_CNT), 1);
        chk("stop_busy", int'(BUSY), 0);
        chk("stop_done", int'(DONE), 0);
        chk("stop_ticks", q.size(), 0);
        go();
        expect_ticks(5, 2, 0);
        step(11);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        chk("div_kept_ticks", q.size(), 0);
        chk("div_kept_cnt", int'(TICK_CNT), 2);

        // START+STOP in IDLE, START during RUN
        START = 1'b1;
        STOP  = 1'b1;
        step(1);
        START = 1'b0;
        STOP  = 1'b0;
        chk("start_stop_busy", int'(BUSY), 0);
        chk("start_stop_ready", int'(CFG_READY), 1);
        cfg(4, 0);
        go();
        expect_ticks(4, 2, 0);
        step(2);
        START = 1'b1;
        step(1);
        START = 1'b0;
        step(6);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        chk("restart_ignored_ticks", q.size(), 0);
        chk("restart_ignored_cnt", int'(TICK_CNT), 2);

`ifdef CLK_TICK_CTRL_SQUARE_EN
        // square output with DIV=2
        cfg(2, 0);
        go();
        expect_ticks(2, 3, 0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk("square_out", int'(CLK_DIV_OUT), ((k % 4) == 2 || (k % 4) == 3) ? 1 : 0);
        end
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        chk("square_after_stop", int'(CLK_DIV_OUT), 0);
        chk("square_ticks", q.size(), 0);
`endif

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
